// File: rtl/counter_bus_arbiter_if.sv
// Bus bundle between two requesting masters, the arbiter, and the downstream register block.
interface counter_bus_arbiter_if;
  logic        m0_valid;
  logic [3:0]  m0_wstrb;
  logic [3:0]  m0_addr;
  logic [31:0] m0_wdata;
  logic [31:0] m0_rdata;
  logic        m0_ready;

  logic        m1_valid;
  logic [3:0]  m1_wstrb;
  logic [3:0]  m1_addr;
  logic [31:0] m1_wdata;
  logic [31:0] m1_rdata;
  logic        m1_ready;

  logic [3:0]  reg_we;
  logic [3:0]  reg_re;
  logic [3:0]  reg_addr;
  logic [31:0] reg_di;
  logic [31:0] reg_do;
  logic        reg_ready;
  logic        timeout;

  modport slave (
    input  m0_valid, m0_wstrb, m0_addr, m0_wdata,
    output m0_rdata, m0_ready,
    input  m1_valid, m1_wstrb, m1_addr, m1_wdata,
    output m1_rdata, m1_ready,
    output reg_we, reg_re, reg_addr, reg_di,
    input  reg_do, reg_ready,
    output timeout
  );

  modport master (
    output m0_valid, m0_wstrb, m0_addr, m0_wdata,
    input  m0_rdata, m0_ready,
    output m1_valid, m1_wstrb, m1_addr, m1_wdata,
    input  m1_rdata, m1_ready,
    input  reg_we, reg_re, reg_addr, reg_di,
    output reg_do, reg_ready,
    input  timeout
  );
endinterface

// File: rtl/counter_bus_arbiter.sv
// Round-robin arbiter for two masters onto one register bus, one transaction in flight.
// ACCESS waits up to TIMEOUT cycles for reg_ready, then completes with all-ones read data.
module counter_bus_arbiter #(
  parameter int TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  counter_bus_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

  state_t      state, state_nx;
  logic        gnt, last_grant, to_flag;
  logic [3:0]  wstrb_q, addr_q;
  logic [31:0] wdata_q, rdata_q;
  logic [7:0]  cnt;
  logic        any_req, win, is_read;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx      = state;
    any_req       = bus.m0_valid | bus.m1_valid;
    // On a tie the master not served last wins; otherwise the lone requester.
    win           = (bus.m0_valid & bus.m1_valid) ? ~last_grant : bus.m1_valid;
    is_read       = (wstrb_q == 4'b0000);
    bus.reg_we    = 4'b0000;
    bus.reg_re    = 4'b0000;
    bus.reg_addr  = addr_q;
    bus.reg_di    = wdata_q;
    bus.m0_ready  = 1'b0;
    bus.m1_ready  = 1'b0;
    bus.m0_rdata  = 32'h0;
    bus.m1_rdata  = 32'h0;
    bus.timeout   = 1'b0;
    case (state)
      IDLE: begin
        if (any_req) state_nx = ACCESS;
      end
      ACCESS: begin
        if (is_read) bus.reg_re = 4'b1111;
        else         bus.reg_we = wstrb_q;
        if (bus.reg_ready || cnt == LAST) state_nx = DONE;
      end
      DONE: begin
        bus.m0_ready = ~gnt;
        bus.m1_ready = gnt;
        bus.m0_rdata = gnt ? 32'h0 : rdata_q;
        bus.m1_rdata = gnt ? rdata_q : 32'h0;
        bus.timeout  = to_flag;
        state_nx     = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gnt        <= 1'b0;
      last_grant <= 1'b1;
      wstrb_q    <= 4'b0000;
      addr_q     <= 4'h0;
      wdata_q    <= 32'h0;
      rdata_q    <= 32'h0;
      cnt        <= 8'd0;
      to_flag    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          cnt     <= 8'd0;
          to_flag <= 1'b0;
          if (any_req) begin
            gnt     <= win;
            wstrb_q <= win ? bus.m1_wstrb : bus.m0_wstrb;
            addr_q  <= win ? bus.m1_addr  : bus.m0_addr;
            wdata_q <= win ? bus.m1_wdata : bus.m0_wdata;
          end
        end
        ACCESS: begin
          cnt <= cnt + 8'd1;
          // A late reg_ready on the expiry cycle still counts as normal completion.
          if (bus.reg_ready) begin
            rdata_q <= is_read ? bus.reg_do : 32'h0;
            to_flag <= 1'b0;
          end else if (cnt == LAST) begin
            rdata_q <= 32'hFFFF_FFFF;
            to_flag <= 1'b1;
          end
        end
        DONE: last_grant <= gnt;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_counter_bus_arbiter.sv
// Directed bench for counter_bus_arbiter: reads, writes, round-robin, timeout and reset abort.
module tb_counter_bus_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   n;

  counter_bus_arbiter_if bus();

  counter_bus_arbiter #(.TIMEOUT(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    bus.m0_valid = 0; bus.m0_wstrb = 0; bus.m0_addr = 0; bus.m0_wdata = 0;
    bus.m1_valid = 0; bus.m1_wstrb = 0; bus.m1_addr = 0; bus.m1_wdata = 0;
    bus.reg_do = 0; bus.reg_ready = 0;

    tick(); tick();
    chk("rst_m0_ready", 32'(bus.m0_ready), 0);
    chk("rst_m1_ready", 32'(bus.m1_ready), 0);
    chk("rst_reg_we", 32'(bus.reg_we), 0);
    chk("rst_reg_re", 32'(bus.reg_re), 0);
    chk("rst_reg_addr", 32'(bus.reg_addr), 0);
    chk("rst_reg_di", bus.reg_di, 0);
    chk("rst_timeout", 32'(bus.timeout), 0);
    chk("rst_m0_rdata", bus.m0_rdata, 0);
    reset = 0;

    // m0 read, combinational ready
    bus.m0_valid = 1; bus.m0_wstrb = 4'b0000; bus.m0_addr = 4'd2;
    bus.reg_do = 32'h0000_0123; bus.reg_ready = 1;
    tick();
    chk("rd_reg_re", 32'(bus.reg_re), 32'hF);
    chk("rd_reg_we", 32'(bus.reg_we), 0);
    chk("rd_reg_addr", 32'(bus.reg_addr), 2);
    chk("rd_m0_ready_early", 32'(bus.m0_ready), 0);
    tick();
    chk("rd_m0_ready", 32'(bus.m0_ready), 1);
    chk("rd_m0_rdata", bus.m0_rdata, 32'h123);
    chk("rd_m1_ready", 32'(bus.m1_ready), 0);
    chk("rd_reg_re_done", 32'(bus.reg_re), 0);
    bus.m0_valid = 0;
    tick();
    chk("rd_m0_ready_after", 32'(bus.m0_ready), 0);

    // m1 write, registered ready
    bus.reg_ready = 0;
    bus.m1_valid = 1; bus.m1_wstrb = 4'b1111; bus.m1_addr = 4'd1; bus.m1_wdata = 32'h10;
    tick();
    chk("wr_reg_we_c1", 32'(bus.reg_we), 32'hF);
    chk("wr_reg_re", 32'(bus.reg_re), 0);
    chk("wr_reg_addr", 32'(bus.reg_addr), 1);
    chk("wr_reg_di", bus.reg_di, 32'h10);
    tick();
    chk("wr_reg_we_c2", 32'(bus.reg_we), 32'hF);
    chk("wr_m1_ready_early", 32'(bus.m1_ready), 0);
    bus.reg_ready = 1;
    tick();
    chk("wr_m1_ready", 32'(bus.m1_ready), 1);
    chk("wr_m1_rdata", bus.m1_rdata, 0);
    chk("wr_m0_ready", 32'(bus.m0_ready), 0);
    chk("wr_reg_we_done", 32'(bus.reg_we), 0);
    bus.m1_valid = 0; bus.reg_ready = 0;
    tick();

    // Both masters valid continuously after reset: m0, m1, m0, m1
    reset = 1; tick(); reset = 0;
    bus.m0_valid = 1; bus.m0_wstrb = 0; bus.m0_addr = 4'd3;
    bus.m1_valid = 1; bus.m1_wstrb = 0; bus.m1_addr = 4'd4;
    bus.reg_ready = 1; bus.reg_do = 32'h0000_00AA;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("rr%0d_addr", i), 32'(bus.reg_addr), (i % 2 == 0) ? 32'd3 : 32'd4);
      tick();
      chk($sformatf("rr%0d_m0_ready", i), 32'(bus.m0_ready), (i % 2 == 0) ? 32'd1 : 32'd0);
      chk($sformatf("rr%0d_m1_ready", i), 32'(bus.m1_ready), (i % 2 == 0) ? 32'd0 : 32'd1);
      chk($sformatf("rr%0d_m0_rdata", i), bus.m0_rdata, (i % 2 == 0) ? 32'hAA : 32'h0);
      chk($sformatf("rr%0d_m1_rdata", i), bus.m1_rdata, (i % 2 == 0) ? 32'h0 : 32'hAA);
      tick();
    end
    bus.m0_valid = 0; bus.m1_valid = 0;
    tick(); tick(); tick();

    // Timeout: reg_ready stuck low
    bus.reg_ready = 0;
    bus.m0_valid = 1; bus.m0_wstrb = 4'b0011; bus.m0_addr = 4'd5; bus.m0_wdata = 32'hDEAD;
    n = 0;
    tick();
    while (bus.reg_we == 4'b0011 && n < 40) begin
      n++;
      tick();
    end
    chk("to_access_cycles", n, 16);
    chk("to_m0_ready", 32'(bus.m0_ready), 1);
    chk("to_m0_rdata", bus.m0_rdata, 32'hFFFF_FFFF);
    chk("to_pulse", 32'(bus.timeout), 1);
    bus.m0_valid = 0;
    tick();
    chk("to_pulse_end", 32'(bus.timeout), 0);
    chk("to_m0_ready_end", 32'(bus.m0_ready), 0);

    // reg_ready arrives on the 16th ACCESS cycle: normal completion
    bus.m1_valid = 1; bus.m1_wstrb = 0; bus.m1_addr = 4'd6; bus.reg_do = 32'h55;
    tick();
    for (int k = 0; k < 15; k++) tick();
    chk("late_still_access", 32'(bus.reg_re), 32'hF);
    bus.reg_ready = 1;
    tick();
    chk("late_m1_ready", 32'(bus.m1_ready), 1);
    chk("late_m1_rdata", bus.m1_rdata, 32'h55);
    chk("late_no_timeout", 32'(bus.timeout), 0);
    bus.m1_valid = 0; bus.reg_ready = 0;
    tick();

    // Reset in the middle of ACCESS
    bus.m0_valid = 1; bus.m0_wstrb = 0; bus.m0_addr = 4'd8;
    tick();
    chk("rstmid_reg_re_before", 32'(bus.reg_re), 32'hF);
    reset = 1;
    #1;
    chk("rstmid_reg_re_drop", 32'(bus.reg_re), 0);
    bus.m0_valid = 0;
    tick();
    chk("rstmid_m0_ready_a", 32'(bus.m0_ready), 0);
    tick();
    chk("rstmid_m0_ready_b", 32'(bus.m0_ready), 0);
    reset = 0;
    bus.m1_valid = 1; bus.m1_wstrb = 4'b1111; bus.m1_addr = 4'd7; bus.m1_wdata = 32'h77;
    bus.reg_ready = 1;
    chk("rstmid_idle_we", 32'(bus.reg_we), 0);
    tick();
    chk("rstmid_m1_we", 32'(bus.reg_we), 32'hF);
    chk("rstmid_m1_addr", 32'(bus.reg_addr), 7);
    chk("rstmid_m0_ready_c", 32'(bus.m0_ready), 0);
    tick();
    chk("rstmid_m1_ready", 32'(bus.m1_ready), 1);
    chk("rstmid_m0_ready_d", 32'(bus.m0_ready), 0);
    bus.m1_valid = 0; bus.reg_ready = 0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
